// File: rtl/dffram_dp_clr.sv
// Dual-port (1R/1W) behavioural RAM with byte-lane writes, write-first bypass,
// optional output register and a hardware clear sweep gated by READY.
module dffram_dp_clr #(
   parameter int WSIZE = 4,
   parameter int DW    = 32,
   parameter int PIPE  = 0,
   localparam int NB    = DW / 8,
   localparam int DEPTH = 256 * WSIZE,
   localparam int AW    = 8 + $clog2(WSIZE)
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          INIT,
   output logic          READY,
   input  logic          EN_W,
   input  logic [NB-1:0] WE,
   input  logic [AW-1:0] A_W,
   input  logic [DW-1:0] Di,
   input  logic          EN_R,
   input  logic [AW-1:0] A_R,
   output logic [DW-1:0] Do,
   output logic          Do_VALID
);

   typedef enum logic {ST_CLEAR, ST_READY} state_t;

   localparam logic [AW:0] CNT_LAST = (AW + 1)'(DEPTH - 1);

   state_t        state_q, state_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] rdMerged;
   logic [DW-1:0] s1Data_q, s1Data_d;
   logic          s1Valid_q, s1Valid_d;

   assign READY = (state_q == ST_READY);

   // Write-first bypass: lanes being written this cycle to the read address return new data.
   always_comb begin
      rdMerged = mem[A_R];
      for (int i = 0; i < NB; i++) begin
         if (EN_W && WE[i] && (A_W == A_R)) begin
            rdMerged[8*i +: 8] = Di[8*i +: 8];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      s1Data_d  = '0;
      s1Valid_d = 1'b0;
      case (state_q)
         ST_CLEAR: begin
            if (cnt_q == CNT_LAST) begin
               state_d = ST_READY;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_READY: begin
            if (EN_R) begin
               s1Data_d  = rdMerged;
               s1Valid_d = 1'b1;
            end
            if (INIT) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= ST_CLEAR;
         cnt_q     <= '0;
         s1Data_q  <= '0;
         s1Valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         s1Data_q  <= s1Data_d;
         s1Valid_q <= s1Valid_d;
      end
   end

   // The array itself has no reset; the clear sweep owns the write port while not READY.
   always_ff @(posedge CLK) begin
      if (state_q == ST_CLEAR) begin
         mem[cnt_q[AW-1:0]] <= '0;
      end else if (EN_W) begin
         for (int i = 0; i < NB; i++) begin
            if (WE[i]) begin
               mem[A_W][8*i +: 8] <= Di[8*i +: 8];
            end
         end
      end
   end

   if (PIPE != 0) begin : g_pipe
      logic [DW-1:0] s2Data_q;
      logic          s2Valid_q;

      always_ff @(posedge CLK or negedge RST_N) begin
         if (!RST_N) begin
            s2Data_q  <= '0;
            s2Valid_q <= 1'b0;
         end else begin
            s2Data_q  <= s1Data_q;
            s2Valid_q <= s1Valid_q;
         end
      end

      assign Do       = s2Data_q;
      assign Do_VALID = s2Valid_q;
   end else begin : g_nopipe
      assign Do       = s1Data_q;
      assign Do_VALID = s1Valid_q;
   end

endmodule

// File: tb/tb_dffram_dp_clr.sv
// Scoreboard bench driving a PIPE=0 and a PIPE=1 instance with identical stimulus.
module tb_dffram_dp_clr;

   localparam int WSIZE = 1;
   localparam int DW    = 32;
   localparam int NB    = DW / 8;
   localparam int AW    = 8;
   localparam int DEPTH = 256;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b1;
   logic          INIT = 1'b0;
   logic          EN_W = 1'b0;
   logic          EN_R = 1'b0;
   logic [NB-1:0] WE = '0;
   logic [AW-1:0] A_W = '0;
   logic [AW-1:0] A_R = '0;
   logic [DW-1:0] Di = '0;

   logic          ready0, ready1, valid0, valid1;
   logic [DW-1:0] do0, do1;

   int nCompared = 0;
   int nMismatched = 0;
   int cyc = 0;
   bit mdlReady = 1'b0;

   logic [DW-1:0] mdl [DEPTH];
   logic [DW-1:0] expQ0[$];
   logic [DW-1:0] expQ1[$];
   int            dueQ0[$];
   int            dueQ1[$];

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc++;

   dffram_dp_clr #(.WSIZE(WSIZE), .DW(DW), .PIPE(0)) dut0 (
      .CLK(CLK), .RST_N(RST_N), .INIT(INIT), .READY(ready0),
      .EN_W(EN_W), .WE(WE), .A_W(A_W), .Di(Di),
      .EN_R(EN_R), .A_R(A_R), .Do(do0), .Do_VALID(valid0)
   );

   dffram_dp_clr #(.WSIZE(WSIZE), .DW(DW), .PIPE(1)) dut1 (
      .CLK(CLK), .RST_N(RST_N), .INIT(INIT), .READY(ready1),
      .EN_W(EN_W), .WE(WE), .A_W(A_W), .Di(Di),
      .EN_R(EN_R), .A_R(A_R), .Do(do1), .Do_VALID(valid1)
   );

   // Scoreboard: each negedge either a read is due (valid + data) or the port must idle at zero.
   always @(negedge CLK) begin
      if (dueQ0.size() > 0 && dueQ0[0] < cyc) begin
         nCompared++; nMismatched++;
         $display("[TB] FAIL overdue0: read due at cycle %0d not delivered by %0d", dueQ0[0], cyc);
         void'(dueQ0.pop_front()); void'(expQ0.pop_front());
      end
      nCompared++;
      if (dueQ0.size() > 0 && dueQ0[0] == cyc) begin
         if (valid0 !== 1'b1 || do0 !== expQ0[0]) begin
            nMismatched++;
            $display("[TB] FAIL read0 @%0d: got valid=%b Do=%h expected valid=1 Do=%h", cyc, valid0, do0, expQ0[0]);
         end
         void'(dueQ0.pop_front()); void'(expQ0.pop_front());
      end else if (valid0 !== 1'b0 || do0 !== '0) begin
         nMismatched++;
         $display("[TB] FAIL idle0 @%0d: got valid=%b Do=%h expected valid=0 Do=0", cyc, valid0, do0);
      end

      if (dueQ1.size() > 0 && dueQ1[0] < cyc) begin
         nCompared++; nMismatched++;
         $display("[TB] FAIL overdue1: read due at cycle %0d not delivered by %0d", dueQ1[0], cyc);
         void'(dueQ1.pop_front()); void'(expQ1.pop_front());
      end
      nCompared++;
      if (dueQ1.size() > 0 && dueQ1[0] == cyc) begin
         if (valid1 !== 1'b1 || do1 !== expQ1[0]) begin
            nMismatched++;
            $display("[TB] FAIL read1 @%0d: got valid=%b Do=%h expected valid=1 Do=%h", cyc, valid1, do1, expQ1[0]);
         end
         void'(dueQ1.pop_front()); void'(expQ1.pop_front());
      end else if (valid1 !== 1'b0 || do1 !== '0) begin
         nMismatched++;
         $display("[TB] FAIL idle1 @%0d: got valid=%b Do=%h expected valid=0 Do=0", cyc, valid1, do1);
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Drives one cycle of traffic and updates the reference model / scoreboard.
   task automatic drive(input logic ew, input logic [NB-1:0] we, input logic [AW-1:0] aw,
                        input logic [DW-1:0] di, input logic er, input logic [AW-1:0] ar,
                        input logic init);
      logic [DW-1:0] expv;
      EN_W = ew; WE = we; A_W = aw; Di = di; EN_R = er; A_R = ar; INIT = init;
      if (mdlReady) begin
         if (er) begin
            expv = mdl[ar];
            if (ew && aw == ar) begin
               for (int i = 0; i < NB; i++) if (we[i]) expv[8*i +: 8] = di[8*i +: 8];
            end
            expQ0.push_back(expv); dueQ0.push_back(cyc + 1);
            expQ1.push_back(expv); dueQ1.push_back(cyc + 2);
         end
         if (ew) begin
            for (int i = 0; i < NB; i++) if (we[i]) mdl[aw][8*i +: 8] = di[8*i +: 8];
         end
         if (init) begin
            mdlReady = 1'b0;
            for (int a = 0; a < DEPTH; a++) mdl[a] = '0;
         end
      end
      tick();
      EN_W = 1'b0; WE = '0; EN_R = 1'b0; INIT = 1'b0;
   endtask

   // Runs exactly DEPTH cycles of a clear sweep while trying to read; READY must rise on the last.
   task automatic waitClear(input string tag);
      int early = 0;
      for (int k = 1; k <= DEPTH; k++) begin
         drive(1'b0, '0, '0, '0, 1'b1, AW'(k), 1'b0);
         if (k < DEPTH && (ready0 !== 1'b0 || ready1 !== 1'b0)) early++;
      end
      nCompared++;
      if (early != 0) begin
         nMismatched++;
         $display("[TB] FAIL %s_low: READY high in %0d of %0d clear cycles, expected 0", tag, early, DEPTH - 1);
      end
      nCompared++;
      if (ready0 !== 1'b1 || ready1 !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL %s_rise: got READY=%b/%b expected 1/1 after %0d cycles", tag, ready0, ready1, DEPTH);
      end
      mdlReady = 1'b1;
   endtask

   task automatic applyReset(input string tag);
      RST_N = 1'b0;
      mdlReady = 1'b0;
      expQ0.delete(); dueQ0.delete(); expQ1.delete(); dueQ1.delete();
      for (int a = 0; a < DEPTH; a++) mdl[a] = '0;
      #1;
      nCompared++;
      if ({ready0, valid0, do0, ready1, valid1, do1} !== '0) begin
         nMismatched++;
         $display("[TB] FAIL %s_state: got READY=%b/%b VALID=%b/%b Do=%h/%h expected all 0",
                  tag, ready0, ready1, valid0, valid1, do0, do1);
      end
      tick();
      RST_N = 1'b1;
      waitClear(tag);
   endtask

   task automatic test_reset();
      #2;
      applyReset("reset");
   endtask

   task automatic test_clear_reads();
      drive(1'b0, '0, '0, '0, 1'b1, 8'h00, 1'b0);
      drive(1'b0, '0, '0, '0, 1'b1, 8'h7F, 1'b0);
      drive(1'b0, '0, '0, '0, 1'b1, 8'hFF, 1'b0);
      repeat (3) tick();
   endtask

   task automatic test_byte_lanes();
      drive(1'b1, 4'b1111, 8'h10, 32'hDEADBEEF, 1'b0, '0, 1'b0);
      drive(1'b1, 4'b0101, 8'h10, 32'h11223344, 1'b0, '0, 1'b0);
      drive(1'b0, '0, '0, '0, 1'b1, 8'h10, 1'b0);
      repeat (3) tick();
      nCompared++;
      if (mdl[8'h10] !== 32'hDE22BE44) begin
         nMismatched++;
         $display("[TB] FAIL lane_model: got %h expected DE22BE44", mdl[8'h10]);
      end
   endtask

   task automatic test_collision();
      drive(1'b1, 4'b1111, 8'h20, 32'hAAAAAAAA, 1'b0, '0, 1'b0);
      drive(1'b1, 4'b0011, 8'h20, 32'h55555555, 1'b1, 8'h20, 1'b0);
      drive(1'b0, '0, '0, '0, 1'b1, 8'h20, 1'b0);
      drive(1'b1, 4'b0000, 8'h20, 32'hFFFFFFFF, 1'b1, 8'h20, 1'b0);
      drive(1'b0, '0, '0, '0, 1'b1, 8'h20, 1'b0);
      repeat (3) tick();
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 4'b1111, 8'h01, 32'd1, 1'b0, '0, 1'b0);
      drive(1'b1, 4'b1111, 8'h02, 32'd2, 1'b0, '0, 1'b0);
      drive(1'b1, 4'b1111, 8'h03, 32'd3, 1'b0, '0, 1'b0);
      tick();
      drive(1'b0, '0, '0, '0, 1'b1, 8'h01, 1'b0);
      drive(1'b0, '0, '0, '0, 1'b1, 8'h02, 1'b0);
      drive(1'b0, '0, '0, '0, 1'b1, 8'h03, 1'b0);
      repeat (4) tick();
   endtask

   task automatic test_init_inflight();
      drive(1'b1, 4'b1111, 8'h05, 32'hCAFEF00D, 1'b0, '0, 1'b0);
      drive(1'b0, '0, '0, '0, 1'b1, 8'h05, 1'b1);
      waitClear("init");
      drive(1'b0, '0, '0, '0, 1'b1, 8'h05, 1'b0);
      repeat (3) tick();
   endtask

   task automatic test_reset_inflight();
      drive(1'b1, 4'b1111, 8'h30, 32'h0BADCAFE, 1'b0, '0, 1'b0);
      drive(1'b0, '0, '0, '0, 1'b1, 8'h30, 1'b0);
      applyReset("rst_inflight");
   endtask

   task automatic test_reset_mid_clear();
      drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
      repeat (100) tick();
      applyReset("rst_midclear");
      drive(1'b0, '0, '0, '0, 1'b1, 8'h30, 1'b0);
      repeat (3) tick();
   endtask

   initial begin
      test_reset();
      test_clear_reads();
      test_byte_lanes();
      test_collision();
      test_back_to_back();
      test_init_inflight();
      test_reset_inflight();
      test_reset_mid_clear();
      nCompared++;
      if (dueQ0.size() != 0 || dueQ1.size() != 0) begin
         nMismatched++;
         $display("[TB] FAIL drain: got %0d/%0d reads pending expected 0/0", dueQ0.size(), dueQ1.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/dffram_dp_clr.md
Name: dffram_dp_clr

Overview:
- Parametrised successor to the single-port behavioural DFFRAM model, for simulation and DV.
- Provides separate read and write ports (one each, same clock), generic data width and byte-lane write enables, and an optional output pipeline register.
- Adds write-first collision bypass and a hardware clear sequencer that zeroes the array after reset or on request, with a READY handshake.
- Sits beside the processor/Wishbone glue as drop-in RAM for testbenches.

Parameters:
- WSIZE, 4, depth in units of 256 words; DEPTH = 256*WSIZE; AW = 8+$clog2(WSIZE).
- DW, 32, data width in bits; must be a multiple of 8; NB = DW/8 byte lanes.
- PIPE, 0, read latency select: 0 gives 1-cycle latency; 1 adds an output register for 2-cycle latency.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RST_N  input  1  asynchronous, active-low reset.
- INIT  input  1  request to clear the whole array; sampled only while READY=1.
- READY  output  1  high when the array is accessible; low during clear.
- EN_W  input  1  write port enable.
- WE  input  NB  byte-lane write enables; lane i covers Di[8i+7:8i].
- A_W  input  AW  write address.
- Di  input  DW  write data.
- EN_R  input  1  read port enable.
- A_R  input  AW  read address.
- Do  output  DW  read data.
- Do_VALID  output  1  qualifies Do.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - READY=0, Do=0, Do_VALID=0.
  - Clear counter = 0; FSM enters CLEAR.
  - Array contents are not reset directly.
- FSM states:
  - CLEAR → READY after the write to address DEPTH-1.
  - READY → CLEAR on a posedge with INIT=1.
- CLEAR:
  - Writes all-zero to address cnt each cycle; cnt increments from 0 to DEPTH-1.
  - Takes DEPTH cycles after RST_N release. READY rises on the edge that writes address DEPTH-1, so it is observed high the cycle after.
  - EN_R, EN_W and INIT are ignored; no new reads are launched; Do_VALID=0 for new reads.
- Asserting RST_N=0 mid-clear aborts the sweep. The sweep restarts from address 0 on release.
- INIT with access in the same READY cycle: the read and write in that cycle complete normally. CLEAR starts on the next cycle, so that write is subsequently zeroed.
- Write (READY=1, EN_W=1): at posedge, each lane i with WE[i]=1 updates RAM[A_W] lane i. Lanes with WE[i]=0 are untouched. EN_W=1 with WE=0 is a no-op.
- Read (READY=1, EN_R=1):
  - Stage 1 captures RAM[A_R] at posedge.
  - PIPE=0: Do/Do_VALID update at that edge (1-cycle latency).
  - PIPE=1: stage 2 register copies stage 1 on the next edge (2-cycle latency). Do_VALID follows the same pipeline.
- Read not launched (EN_R=0 or READY=0): the corresponding stage loads Do=0 and Do_VALID=0. This matches the predecessor zero-on-disable semantics.
- Collision (EN_R & EN_W & A_R==A_W in the same cycle): write-first, per lane.
  - Lanes with WE[i]=1 return Di lane i.
  - Other lanes return the old contents.
- In-flight read when INIT is accepted (PIPE=1): stage 2 still delivers its data and Do_VALID on the following edge.
- In-flight read lost at reset: an asynchronous reset clears both pipeline stages.
- Addresses are always in range: AW bits exactly span DEPTH, so there is no wrap or out-of-range case.
- Width rules:
  - cnt is AW+1 bits; terminal compare is against DEPTH-1.
  - Do is DW bits; all lanes are independent.

Test Plan:
- Clear after reset (WSIZE=1, DW=32):
  - Release RST_N → READY=0 for exactly 256 cycles, then 1.
  - Read addresses 0, 0x7F and 0xFF → Do=0x00000000 with Do_VALID=1 one cycle after each request.
- Byte lanes (PIPE=0):
  - Write A_W=0x10, Di=0xDEADBEEF, WE=4'b1111.
  - Then write Di=0x11223344, WE=4'b0101.
  - Read 0x10 → Do=0xDE22BE44 on the next edge.
- Collision:
  - Preload 0x20 with 0xAAAAAAAA.
  - Same cycle: write 0x20 with Di=0x55555555, WE=4'b0011, and read 0x20 → Do=0xAAAA5555.
  - Next-cycle read → Do=0xAAAA5555.
- Pipeline (PIPE=1): back-to-back reads of 0x01, 0x02 and 0x03 holding 1, 2 and 3 → Do=1, 2, 3 on edges +2, +3, +4. Do_VALID=1 on exactly those three edges, and Do=0 otherwise.
- INIT with in-flight traffic (PIPE=1):
  - Write 0x05=0xCAFEF00D; pulse INIT together with a read of 0x05 → Do=0xCAFEF00D is delivered, then READY=0 for 256 cycles.
  - During clear, EN_R is ignored (Do_VALID=0).
  - After clear, a read of 0x05 → 0.
- Reset mid-clear: drop RST_N at cnt=100 for 1 cycle → Do=0, Do_VALID=0 and READY=0 immediately; READY rises 256 cycles after release.
